// File: rtl/bram_access_arbiter.sv
// Arbitrates the single-port 256-byte BRAM between the CPU (read/write) and the
// LCD debug viewer (read-only). Each grant runs a fixed 4-cycle sequence.
module bram_access_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int DBG_MAX_WAIT = 4,
  localparam int CNT_W       = $clog2(DBG_MAX_WAIT + 1)
) (
  input  logic              qzt_clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_pending,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_pending,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner,
  output logic [1:0]        fsm_state,
  output logic [CNT_W-1:0]  wait_cnt
);

  // Handshake: a req strobe is accepted when its port is not pending (or is
  // being granted on that same edge); pending stays high until the grant, and
  // the port's ack pulses for one cycle when the transaction is complete.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(DBG_MAX_WAIT);

  state_t              state;
  logic                cpu_we_q;
  logic [ADDR_W-1:0]   cpu_addr_q;
  logic [DATA_W-1:0]   cpu_wdata_q;
  logic [ADDR_W-1:0]   dbg_addr_q;
  logic                txn_read;
  logic                grant_cpu;
  logic                grant_dbg;

  assign fsm_state = state;

  // Debug is forced only once the CPU has won MAX_WAIT times in a row over it.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (state == S_IDLE) begin
      grant_cpu = cpu_pending && (!dbg_pending || (wait_cnt != MAX_WAIT));
      grant_dbg = dbg_pending && !grant_cpu;
    end
  end

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cpu_pending <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      dbg_pending <= 1'b0;
      dbg_addr_q  <= '0;
      wait_cnt    <= '0;
      txn_read    <= 1'b0;
      owner       <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;

      if (cpu_req && (!cpu_pending || grant_cpu)) begin
        cpu_pending <= 1'b1;
        cpu_we_q    <= cpu_we;
        cpu_addr_q  <= cpu_addr;
        cpu_wdata_q <= cpu_wdata;
      end else if (grant_cpu) begin
        cpu_pending <= 1'b0;
      end

      if (dbg_req && (!dbg_pending || grant_dbg)) begin
        dbg_pending <= 1'b1;
        dbg_addr_q  <= dbg_addr;
      end else if (grant_dbg) begin
        dbg_pending <= 1'b0;
      end

      if (grant_dbg) begin
        wait_cnt <= '0;
      end else if (grant_cpu && dbg_pending && (wait_cnt != MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (grant_cpu) begin
            ram_en    <= 1'b1;
            ram_we    <= cpu_we_q;
            ram_addr  <= cpu_addr_q;
            ram_wdata <= cpu_wdata_q;
            owner     <= 1'b0;
            txn_read  <= !cpu_we_q;
            state     <= S_ISSUE;
          end else if (grant_dbg) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= dbg_addr_q;
            ram_wdata <= '0;
            owner     <= 1'b1;
            txn_read  <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // BRAM output is valid now; writes leave the CPU read register alone.
          if (owner) begin
            dbg_rdata <= ram_rdata;
            dbg_ack   <= 1'b1;
          end else begin
            if (txn_read) cpu_rdata <= ram_rdata;
            cpu_ack <= 1'b1;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Randomized and directed bench for bram_access_arbiter with a transaction-level
// reference model (slot timing, arbitration rules, reference memory).
module tb_bram_access_arbiter;

  localparam int MAXW = 2;

  logic       qzt_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_pending;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       dbg_req = 1'b0;
  logic [7:0] dbg_addr = '0;
  logic       dbg_pending;
  logic       dbg_ack;
  logic [7:0] dbg_rdata;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       owner;
  logic [1:0] fsm_state;
  logic [1:0] wait_cnt;

  bram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .DBG_MAX_WAIT(MAXW)) dut (
    .qzt_clk(qzt_clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_pending(cpu_pending), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_pending(dbg_pending),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner), .fsm_state(fsm_state), .wait_cnt(wait_cnt)
  );

  // ---------------- clock / reset ----------------
  always #10 qzt_clk = ~qzt_clk;

  // ---------------- BRAM behavioural model ----------------
  logic [7:0] mem [256];
  always @(posedge qzt_clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // ---------------- check task ----------------
  int n_cmp = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  int   cyc = 0;
  int   slot_left = 0;
  int   ack_at = -1;
  int   wr_at = -1;
  bit   ack_own = 0, ack_rd = 0;
  logic [7:0] ack_d = '0, wr_a = '0, wr_d = '0;
  bit   mc_pend = 0, mc_we = 0, md_pend = 0;
  logic [7:0] mc_addr = '0, mc_wdata = '0, md_addr = '0;
  int   m_wait = 0;
  bit   m_cpu_ack = 0, m_dbg_ack = 0, m_ram_en = 0, m_ram_we = 0, m_owner = 0;
  logic [7:0] m_ram_addr = '0, m_cpu_rdata = '0, m_dbg_rdata = '0;
  logic [7:0] cpu_exp_q [$];
  logic [7:0] dbg_exp_q [$];

  always @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_left = 0; ack_at = -1; wr_at = -1;
      mc_pend = 0; md_pend = 0; m_wait = 0;
      m_cpu_ack = 0; m_dbg_ack = 0; m_ram_en = 0; m_ram_we = 0; m_owner = 0;
      m_ram_addr = '0; m_cpu_rdata = '0; m_dbg_rdata = '0;
      cpu_exp_q.delete(); dbg_exp_q.delete();
    end else begin
      cyc++;
      m_cpu_ack = 0; m_dbg_ack = 0; m_ram_en = 0; m_ram_we = 0;
      if (cyc == wr_at) ref_mem[wr_a] = wr_d;
      if (cyc == ack_at) begin
        if (ack_own) begin
          m_dbg_ack = 1; m_dbg_rdata = ack_d;
        end else begin
          m_cpu_ack = 1;
          if (ack_rd) m_cpu_rdata = ack_d;
        end
      end
      // One grant every four edges; CPU first unless debug has waited MAXW wins.
      if (slot_left > 0) begin
        slot_left--;
      end else if (mc_pend || md_pend) begin
        slot_left = 3;
        ack_at = cyc + 2;
        m_ram_en = 1;
        if (mc_pend && (!md_pend || m_wait != MAXW)) begin
          if (md_pend && m_wait < MAXW) m_wait++;
          m_owner = 0; m_ram_we = mc_we; m_ram_addr = mc_addr;
          ack_own = 0; ack_rd = !mc_we;
          ack_d = mc_we ? m_cpu_rdata : ref_mem[mc_addr];
          if (mc_we) begin wr_at = cyc + 1; wr_a = mc_addr; wr_d = mc_wdata; end
          cpu_exp_q.push_back(ack_d);
          mc_pend = 0;
        end else begin
          m_wait = 0;
          m_owner = 1; m_ram_we = 0; m_ram_addr = md_addr;
          ack_own = 1; ack_rd = 1; ack_d = ref_mem[md_addr];
          dbg_exp_q.push_back(ack_d);
          md_pend = 0;
        end
      end
      if (cpu_req && !mc_pend) begin
        mc_pend = 1; mc_we = cpu_we; mc_addr = cpu_addr; mc_wdata = cpu_wdata;
      end
      if (dbg_req && !md_pend) begin
        md_pend = 1; md_addr = dbg_addr;
      end
    end
  end

  // ---------------- scoreboard / per-cycle checks ----------------
  bit chk_on = 0;
  always @(negedge qzt_clk) begin
    if (reset_n && chk_on) begin
      check("cpu_ack", 32'(cpu_ack), 32'(m_cpu_ack));
      check("dbg_ack", 32'(dbg_ack), 32'(m_dbg_ack));
      check("cpu_pending", 32'(cpu_pending), 32'(mc_pend));
      check("dbg_pending", 32'(dbg_pending), 32'(md_pend));
      check("ram_en", 32'(ram_en), 32'(m_ram_en));
      check("ram_we", 32'(ram_we), 32'(m_ram_we));
      check("owner", 32'(owner), 32'(m_owner));
      check("wait_cnt", 32'(wait_cnt), 32'(m_wait));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
      check("dbg_rdata", 32'(dbg_rdata), 32'(m_dbg_rdata));
      if (m_ram_en) check("ram_addr", 32'(ram_addr), 32'(m_ram_addr));
      check("ack_exclusive", 32'(cpu_ack & dbg_ack), 32'(0));
      check("dbg_never_writes", 32'(owner & ram_we), 32'(0));
      check("we_needs_en", 32'(ram_we & ~ram_en), 32'(0));
      if (cpu_ack) begin
        if (cpu_exp_q.size() == 0) check("cpu_ack_spurious", 32'(1), 32'(0));
        else check("cpu_rdata_at_ack", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
      end
      if (dbg_ack) begin
        if (dbg_exp_q.size() == 0) check("dbg_ack_spurious", 32'(1), 32'(0));
        else check("dbg_rdata_at_ack", 32'(dbg_rdata), 32'(dbg_exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input bit c, input bit we, input logic [7:0] ca, input logic [7:0] cd,
                        input bit d, input logic [7:0] da);
    cpu_req = c; cpu_we = we; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = d; dbg_addr = da;
    @(negedge qzt_clk);
    cpu_req = 0; dbg_req = 0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 60; i++) begin
      if (!cpu_pending && !dbg_pending && fsm_state == 2'd0 && !cpu_ack && !dbg_ack) break;
      @(negedge qzt_clk);
    end
    if (i == 60) check({tag, "_idle_timeout"}, 32'(1), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'(0));
    check({tag, "_dbg_ack"}, 32'(dbg_ack), 32'(0));
    check({tag, "_ram_en"}, 32'(ram_en), 32'(0));
    check({tag, "_ram_we"}, 32'(ram_we), 32'(0));
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
    check({tag, "_owner"}, 32'(owner), 32'(0));
    check({tag, "_pending"}, 32'({cpu_pending, dbg_pending}), 32'(0));
    check({tag, "_rdata"}, 32'({cpu_rdata, dbg_rdata}), 32'(0));
    check({tag, "_state"}, 32'(fsm_state), 32'(0));
    check({tag, "_wait_cnt"}, 32'(wait_cnt), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] orig_30;
  int ord [4];
  int k, rs, cpu_t, dbg_t, n_cpu_acks;
  logic [7:0] seen_addr;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    orig_30 = ref_mem[8'h30];

    repeat (3) @(negedge qzt_clk);
    check_all_zero("reset");
    reset_n = 1;
    chk_on = 1;
    @(negedge qzt_clk);

    // 1: CPU write 0x10 <= 0xA5
    strobe(1, 1, 8'h10, 8'hA5, 0, 8'h00);
    @(negedge qzt_clk);
    check("t1_ram_en_E1", 32'(ram_en), 32'(1));
    check("t1_ram_we_E1", 32'(ram_we), 32'(1));
    wait_idle("t1");

    // 2: CPU then debug read back 0x10
    strobe(1, 0, 8'h10, 8'h00, 0, 8'h00);
    wait_idle("t2a");
    check("t2_cpu_rdata", 32'(cpu_rdata), 32'(8'hA5));
    strobe(0, 0, 8'h00, 8'h00, 1, 8'h10);
    wait_idle("t2b");
    check("t2_dbg_rdata", 32'(dbg_rdata), 32'(8'hA5));

    // 3: simultaneous strobes, CPU at E3 then debug at E7
    cpu_t = -1; dbg_t = -1;
    strobe(1, 0, 8'h05, 8'h00, 1, 8'h06);
    for (int i = 0; i < 12; i++) begin
      if (cpu_ack && cpu_t < 0) cpu_t = i;
      if (dbg_ack && dbg_t < 0) dbg_t = i;
      @(negedge qzt_clk);
    end
    check("t3_cpu_ack_cycle", 32'(cpu_t), 32'(3));
    check("t3_dbg_ack_cycle", 32'(dbg_t), 32'(7));
    wait_idle("t3");

    // 4: CPU re-strobes at every DONE while debug waits
    k = 0; rs = 0;
    for (int i = 0; i < 4; i++) ord[i] = -1;
    strobe(1, 0, 8'h01, 8'h00, 1, 8'h02);
    for (int i = 0; i < 40 && k < 3; i++) begin
      if (cpu_ack || dbg_ack) begin ord[k] = int'(dbg_ack); k++; end
      if (cpu_ack && rs < 2) begin
        rs++; cpu_req = 1; cpu_we = 0; cpu_addr = 8'($urandom_range(0, 15));
      end
      @(negedge qzt_clk);
      cpu_req = 0;
    end
    check("t4_order0", 32'(ord[0]), 32'(0));
    check("t4_order1", 32'(ord[1]), 32'(0));
    check("t4_order2", 32'(ord[2]), 32'(1));
    check("t4_wait_cnt", 32'(wait_cnt), 32'(0));
    wait_idle("t4");

    // 5: second CPU strobe while pending is ignored
    strobe(0, 0, 8'h00, 8'h00, 1, 8'h03);
    strobe(1, 0, 8'h11, 8'h00, 0, 8'h00);
    strobe(1, 0, 8'h22, 8'h00, 0, 8'h00);
    n_cpu_acks = 0; seen_addr = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      if (cpu_ack) n_cpu_acks++;
      if (ram_en && !owner) seen_addr = ram_addr;
      @(negedge qzt_clk);
    end
    check("t5_ram_addr", 32'(seen_addr), 32'(8'h11));
    check("t5_one_cpu_ack", 32'(n_cpu_acks), 32'(1));
    wait_idle("t5");

    // randomized traffic on a small address window
    for (int i = 0; i < 400; i++) begin
      cpu_req   = ($urandom_range(0, 3) == 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 8'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      dbg_req   = ($urandom_range(0, 4) == 0);
      dbg_addr  = 8'($urandom_range(0, 15));
      @(negedge qzt_clk);
    end
    cpu_req = 0; dbg_req = 0;
    wait_idle("rand");
    check("rand_cpu_q_drained", 32'(cpu_exp_q.size()), 32'(0));
    check("rand_dbg_q_drained", 32'(dbg_exp_q.size()), 32'(0));

    // 6: reset during ISSUE of a write to 0x30
    strobe(1, 1, 8'h30, 8'h5A, 0, 8'h00);
    @(negedge qzt_clk);
    check("t6_ram_en_issue", 32'(ram_en), 32'(1));
    #2 reset_n = 0;
    #1 check_all_zero("t6_reset");
    repeat (3) @(negedge qzt_clk);
    check_all_zero("t6_held");
    reset_n = 1;
    @(negedge qzt_clk);
    strobe(1, 0, 8'h30, 8'h00, 0, 8'h00);
    wait_idle("t6");
    check("t6_0x30_unwritten", 32'(cpu_rdata), 32'(orig_30));

    repeat (2) @(negedge qzt_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
